ysyx_22040125_wbu: RTL

YSYX_22040125_WBU -- requirements
Module: ysyx_22040125_WBU

---
 rtl/ysyx_22040125_wbu.sv | 100 ++++++++++
 1 files changed

// File: rtl/ysyx_22040125_wbu.sv
// Write-back unit: picks one LSU/ALU result per cycle (LSU first), registers the
// register-file write, tracks outstanding destinations and counts retired results.
module ysyx_22040125_wbu #(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            lsu_valid,
   output logic            lsu_ready,
   input  logic [4:0]      lsu_rd,
   input  logic [XLEN-1:0] lsu_data,
   input  logic            alu_valid,
   output logic            alu_ready,
   input  logic [4:0]      alu_rd,
   input  logic [XLEN-1:0] alu_data,
   input  logic            iss_valid,
   input  logic [4:0]      iss_rd,
   input  logic [4:0]      q_rs1,
   input  logic [4:0]      q_rs2,
   output logic            busy_rs1,
   output logic            busy_rs2,
   output logic            rf_en,
   output logic [4:0]      rf_addr,
   output logic [XLEN-1:0] rf_data,
   output logic [63:0]     retire_cnt
);

   logic            xfer;
   logic [4:0]      sel_rd;
   logic [XLEN-1:0] sel_data;

   logic            rf_en_q,   rf_en_d;
   logic [4:0]      rf_addr_q, rf_addr_d;
   logic [XLEN-1:0] rf_data_q, rf_data_d;
   logic [63:0]     cnt_q,     cnt_d;
   logic [31:0]     busy_q,    busy_d;

   // The LSU result belongs to the older instruction, so it always wins.
   assign lsu_ready = rst_n;
   assign alu_ready = rst_n & ~lsu_valid;

   always_comb begin
      xfer     = 1'b0;
      sel_rd   = alu_rd;
      sel_data = alu_data;
      if (lsu_valid && lsu_ready) begin
         xfer     = 1'b1;
         sel_rd   = lsu_rd;
         sel_data = lsu_data;
      end else if (alu_valid && alu_ready) begin
         xfer = 1'b1;
      end
   end

   always_comb begin
      rf_en_d   = xfer && (sel_rd != 5'd0);
      rf_addr_d = rf_addr_q;
      rf_data_d = rf_data_q;
      if (xfer) begin
         rf_addr_d = sel_rd;
         rf_data_d = sel_data;
      end
      cnt_d = cnt_q + {63'd0, xfer};
   end

   assign busy_d[0] = 1'b0;

   // A new issue to the same register outranks the completing write.
   generate
      for (genvar gi = 1; gi < 32; gi++) begin : g_busy
         assign busy_d[gi] = (iss_valid && (iss_rd == 5'(gi))) ? 1'b1 :
                             (xfer && (sel_rd == 5'(gi)))      ? 1'b0 :
                             busy_q[gi];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rf_en_q   <= 1'b0;
         rf_addr_q <= 5'd0;
         rf_data_q <= '0;
         cnt_q     <= 64'd0;
         busy_q    <= 32'd0;
      end else begin
         rf_en_q   <= rf_en_d;
         rf_addr_q <= rf_addr_d;
         rf_data_q <= rf_data_d;
         cnt_q     <= cnt_d;
         busy_q    <= busy_d;
      end
   end

   assign busy_rs1   = busy_q[q_rs1];
   assign busy_rs2   = busy_q[q_rs2];
   assign rf_en      = rf_en_q;
   assign rf_addr    = rf_addr_q;
   assign rf_data    = rf_data_q;
   assign retire_cnt = cnt_q;

endmodule
